muldiv_sequencer: RTL

Iterative multi-cycle multiply/divide engine and controller. It replaces the single-cycle mult/multu/div/divu paths of the ALU. The decode stage launches an operation, and the block sequences a radix-2 shift-add or restoring-subtract loop. On completion it delivers the 64-bit {HI,LO} result with a one-cycle HI/LO write strobe, and raises busy so the pipeline can stall mfhi/mflo and further muldiv instructions.

---
 rtl/muldiv_sequencer_if.sv | 15 +
 rtl/muldiv_sequencer.sv | 103 ++++++++++
 2 files changed

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: launch/result bundle between the decode stage and the muldiv engine.
interface muldiv_sequencer_if #(parameter int WIDTH = 32);
  logic               start;
  logic [1:0]         op;
  logic [WIDTH-1:0]   rs;
  logic [WIDTH-1:0]   rt;
  logic               cancel;
  logic               busy;
  logic               done;
  logic               hilo_wr_en;
  logic [2*WIDTH-1:0] result;
  logic               divz;
  modport master (output start, op, rs, rt, cancel, input busy, done, hilo_wr_en, result, divz);
  modport slave (input start, op, rs, rt, cancel, output busy, done, hilo_wr_en, result, divz);
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative radix-2 shift-add multiply / restoring divide with HI/LO write strobe.
// Define MULDIV_DIVZ_TRAP_EN to finish divide-by-zero at once with divz set and no HI/LO write.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic clk_cpu,
  input logic reset,
  muldiv_sequencer_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3;
  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               isdiv_q, isdiv_d, qneg_q, qneg_d, rneg_q, rneg_d, divz_q, divz_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, res_q, res_d;
  logic               sgn, is_div, dz, accept, trap;
  logic [WIDTH-1:0]   abs_rs, abs_rt, hi, lo, fix_hi, fix_lo;
  logic [WIDTH:0]     madd, dsh;
  logic [WIDTH+1:0]   dtrial;
  always_comb begin
    sgn = ~bus.op[0];
    is_div = bus.op[1];
    dz = is_div & (bus.rt == '0);
    abs_rs = (sgn & bus.rs[WIDTH-1]) ? -bus.rs : bus.rs;
    abs_rt = (sgn & bus.rt[WIDTH-1]) ? -bus.rt : bus.rt;
    accept = bus.start & ((state_q == IDLE) | (state_q == DONE));
`ifdef MULDIV_DIVZ_TRAP_EN
    trap = dz;
`else
    trap = 1'b0;
`endif
    hi = acc_q[2*WIDTH-1:WIDTH];
    lo = acc_q[WIDTH-1:0];
    // Multiply keeps the carry of the upper-half add so the shifted product stays exact.
    madd = {1'b0, hi} + (lo[0] ? {1'b0, opa_q} : '0);
    dsh = {hi, lo[WIDTH-1]};
    dtrial = {1'b0, dsh} - {2'b0, opa_q};
    fix_hi = rneg_q ? -hi : hi;
    fix_lo = qneg_q ? -lo : lo;
    state_d = state_q;
    cnt_d = cnt_q;
    isdiv_d = isdiv_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    divz_d = divz_q;
    opa_d = opa_q;
    acc_d = acc_q;
    res_d = res_q;
    if (bus.cancel) begin
      state_d = IDLE;
    end else if (accept) begin
      state_d = trap ? DONE : CALC;
      cnt_d = '0;
      isdiv_d = is_div;
      // A zero divisor skips sign fixing so HI returns the raw dividend.
      qneg_d = sgn & ~dz & (bus.rs[WIDTH-1] ^ bus.rt[WIDTH-1]);
      rneg_d = sgn & ~dz & bus.rs[WIDTH-1];
      divz_d = trap;
      opa_d = is_div ? abs_rt : abs_rs;
      acc_d = {{WIDTH{1'b0}}, is_div ? (dz ? bus.rs : abs_rs) : abs_rt};
    end else if (state_q == CALC) begin
      cnt_d = cnt_q + CNT_W'(1);
      acc_d = !isdiv_q ? {madd, lo[WIDTH-1:1]} :
              dtrial[WIDTH+1] ? {dsh[WIDTH-1:0], lo[WIDTH-2:0], 1'b0} :
              {dtrial[WIDTH-1:0], lo[WIDTH-2:0], 1'b1};
      state_d = (cnt_q == CNT_W'(WIDTH-1)) ? FIX : CALC;
    end else if (state_q == FIX) begin
      state_d = DONE;
      res_d = isdiv_q ? {fix_hi, fix_lo} : (qneg_q ? -acc_q : acc_q);
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk_cpu or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      isdiv_q <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      divz_q <= 1'b0;
      opa_q <= '0;
      acc_q <= '0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      isdiv_q <= isdiv_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      divz_q <= divz_d;
      opa_q <= opa_d;
      acc_q <= acc_d;
      res_q <= res_d;
    end
  end
  assign bus.busy = (state_q == CALC) | (state_q == FIX);
  assign bus.done = state_q == DONE;
  assign bus.hilo_wr_en = (state_q == DONE) & ~divz_q;
  assign bus.divz = (state_q == DONE) & divz_q;
  assign bus.result = res_q;
endmodule
